// File: rtl/pong_pkg.sv
// Shared definitions for the pong display path.
//   SCREEN_COLS / SCREEN_ROWS : default LED matrix geometry
//   COORD_W                   : width of the ball x/y coordinates
//   phase_t                   : per-row scan phase (blank gap, then drive)
//   max_u                     : elaboration-time maximum of two sizes
package pong_pkg;

  localparam int unsigned SCREEN_COLS = 16;
  localparam int unsigned SCREEN_ROWS = 8;
  localparam int unsigned COORD_W     = 4;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Index-to-one-hot decoder with enable.
//   idx    : binary index, IW bits
//   en     : when low the output is all zeros
//   onehot : N-bit output; bit idx is set when en is high and idx < N
module onehot_decode #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (idx == IW'(i)) onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// LED matrix row scanner that lights the single ball pixel.
// Each row gets BLANK all-off cycles, then DWELL cycles of drive. The ball
// position is captured once per frame so the image never tears mid-scan.
//   clk, reset  : system clock, synchronous active-high reset
//   ball_x/y    : ball position from the ball block
//   row         : one-hot row enable (inverted at the pins when ACTIVE_LOW)
//   col         : column enables for the active row (same polarity rule)
//   frame_start : one-cycle pulse in the first blank cycle of row 0
module matrix_scan
  import pong_pkg::*;
#(
  parameter int unsigned ROWS       = SCREEN_ROWS,
  parameter int unsigned COLS       = SCREEN_COLS,
  parameter int unsigned DWELL      = 4,
  parameter int unsigned BLANK      = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  output logic [ROWS-1:0]    row,
  output logic [COLS-1:0]    col,
  output logic               frame_start
);

  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PMAX = max_u(DWELL, BLANK);
  localparam int unsigned CW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  // State registers describe the cycle currently shown on the outputs.
  phase_t             phase, nphase;
  logic [RW-1:0]      r, nr;
  logic [CW-1:0]      cnt, ncnt;
  logic               restart;
  logic [COORD_W-1:0] shadow_x, shadow_y;

  logic               nstart;
  logic [COORD_W-1:0] sel_x, sel_y;
  logic               hit;
  logic [ROWS-1:0]    row_dec;
  logic [COLS-1:0]    col_dec;

  // restart is set throughout reset so the first post-reset cycle re-emits
  // the frame-start state instead of advancing past it.
  always_comb begin
    nphase = phase;
    nr     = r;
    ncnt   = cnt;
    if (restart) begin
      nphase = PH_BLANK;
      nr     = '0;
      ncnt   = '0;
    end else if (phase == PH_BLANK) begin
      if (cnt == BLANK_LAST) begin
        nphase = PH_DRIVE;
        ncnt   = '0;
      end else begin
        ncnt = cnt + 1'b1;
      end
    end else begin
      if (cnt == DWELL_LAST) begin
        nphase = PH_BLANK;
        ncnt   = '0;
        nr     = (r == LAST_ROW) ? '0 : r + 1'b1;
      end else begin
        ncnt = cnt + 1'b1;
      end
    end
  end

  assign nstart = (nphase == PH_BLANK) && (nr == '0) && (ncnt == '0);

  // The position is captured at the end of the frame_start cycle; the cycle
  // computed at that same edge must already see the new value, so bypass the
  // shadow registers while frame_start is high.
  assign sel_x = frame_start ? ball_x : shadow_x;
  assign sel_y = frame_start ? ball_y : shadow_y;
  assign hit   = (nphase == PH_DRIVE) && (sel_y == COORD_W'(nr));

  onehot_decode #(.N(ROWS), .IW(RW)) u_row_dec (
    .idx    (nr),
    .en     (nphase == PH_DRIVE),
    .onehot (row_dec)
  );

  onehot_decode #(.N(COLS), .IW(COORD_W)) u_col_dec (
    .idx    (sel_x),
    .en     (hit),
    .onehot (col_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= PH_BLANK;
      r           <= '0;
      cnt         <= '0;
      restart     <= 1'b1;
      shadow_x    <= '0;
      shadow_y    <= '1;
      row         <= {ROWS{ACTIVE_LOW}};
      col         <= {COLS{ACTIVE_LOW}};
      frame_start <= 1'b0;
    end else begin
      phase       <= nphase;
      r           <= nr;
      cnt         <= ncnt;
      restart     <= 1'b0;
      if (frame_start) begin
        shadow_x <= ball_x;
        shadow_y <= ball_y;
      end
      row         <= row_dec ^ {ROWS{ACTIVE_LOW}};
      col         <= col_dec ^ {COLS{ACTIVE_LOW}};
      frame_start <= nstart;
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: an active-high and an active-low
// instance share stimulus and are checked against a per-cycle frame model.
module tb_matrix_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ball_x = 4'd0;
  logic [3:0]  ball_y = 4'd0;
  logic [7:0]  row, row_n;
  logic [15:0] col, col_n;
  logic        fs, fs_n;

  always #5 clk = ~clk;

  matrix_scan #(.ROWS(8), .COLS(16), .DWELL(4), .BLANK(1), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .ball_x(ball_x), .ball_y(ball_y),
    .row(row), .col(col), .frame_start(fs)
  );

  matrix_scan #(.ROWS(8), .COLS(16), .DWELL(4), .BLANK(1), .ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .reset(reset), .ball_x(ball_x), .ball_y(ball_y),
    .row(row_n), .col(col_n), .frame_start(fs_n)
  );

  typedef struct packed {
    logic        fs;
    logic [7:0]  row;
    logic [15:0] col;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Cycle k of a frame: k%5==0 is the blank gap of row k/5, else drive.
  function automatic exp_t model(input int k, input int lx, input int ly);
    exp_t e;
    int   r;
    bit   drive;
    r     = k / 5;
    drive = (k % 5) != 0;
    e.fs  = (k == 0);
    e.row = drive ? 8'(32'd1 << r) : 8'h00;
    e.col = (drive && ly == r) ? 16'(32'd1 << lx) : 16'h0000;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset  = 1'b1;
    ball_x = 4'd3;
    ball_y = 4'd2;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(exp_t'('0));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL reset i=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", i, fs, row, col, e.fs, e.row, e.col);
      end
      checks++;
      if ({fs_n, row_n, col_n} !== {e.fs, ~e.row, ~e.col}) begin
        errors++;
        $display("FAIL reset_n i=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", i, fs_n, row_n, col_n, e.fs, ~e.row, ~e.col);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      sbq.push_back(model(k, 3, 2));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL basic k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs, row, col, e.fs, e.row, e.col);
      end
      checks++;
      if ({fs_n, row_n, col_n} !== {e.fs, ~e.row, ~e.col}) begin
        errors++;
        $display("FAIL basic_n k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs_n, row_n, col_n, e.fs, ~e.row, ~e.col);
      end
      if (k == 12) ball_x = 4'd9;
    end
  endtask

  task automatic test_midframe();
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      sbq.push_back(model(k, 9, 2));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL midframe k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs, row, col, e.fs, e.row, e.col);
      end
      checks++;
      if ({fs_n, row_n, col_n} !== {e.fs, ~e.row, ~e.col}) begin
        errors++;
        $display("FAIL midframe_n k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs_n, row_n, col_n, e.fs, ~e.row, ~e.col);
      end
      if (k == 20) begin
        ball_x = 4'd15;
        ball_y = 4'd7;
      end
    end
  endtask

  task automatic test_corner();
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      sbq.push_back(model(k, 15, 7));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL corner k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs, row, col, e.fs, e.row, e.col);
      end
      checks++;
      if ({fs_n, row_n, col_n} !== {e.fs, ~e.row, ~e.col}) begin
        errors++;
        $display("FAIL corner_n k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs_n, row_n, col_n, e.fs, ~e.row, ~e.col);
      end
      if (k == 20) begin
        ball_x = 4'd5;
        ball_y = 4'd8;
      end
    end
  endtask

  task automatic test_offscreen();
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      sbq.push_back(model(k, 5, 8));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL offscreen k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs, row, col, e.fs, e.row, e.col);
      end
      checks++;
      if ({fs_n, row_n, col_n} !== {e.fs, ~e.row, ~e.col}) begin
        errors++;
        $display("FAIL offscreen_n k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs_n, row_n, col_n, e.fs, ~e.row, ~e.col);
      end
      if (k == 20) begin
        ball_x = 4'd6;
        ball_y = 4'd1;
      end
    end
  endtask

  // Reset lands after cycle 23 of a frame, holds two cycles, then a fresh
  // frame with a fresh latch; finishes with the wrap into the next frame.
  task automatic test_reset_midframe();
    exp_t e;
    for (int k = 0; k < 24; k++) begin
      sbq.push_back(model(k, 6, 1));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL pre_reset k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs, row, col, e.fs, e.row, e.col);
      end
    end
    reset  = 1'b1;
    ball_x = 4'd10;
    ball_y = 4'd3;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(exp_t'('0));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL in_reset i=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", i, fs, row, col, e.fs, e.row, e.col);
      end
      checks++;
      if ({fs_n, row_n, col_n} !== {e.fs, ~e.row, ~e.col}) begin
        errors++;
        $display("FAIL in_reset_n i=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", i, fs_n, row_n, col_n, e.fs, ~e.row, ~e.col);
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 41; k++) begin
      sbq.push_back(model(k % 40, 10, 3));
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({fs, row, col} !== {e.fs, e.row, e.col}) begin
        errors++;
        $display("FAIL post_reset k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs, row, col, e.fs, e.row, e.col);
      end
      checks++;
      if ({fs_n, row_n, col_n} !== {e.fs, ~e.row, ~e.col}) begin
        errors++;
        $display("FAIL post_reset_n k=%0d got fs=%b row=%h col=%h want fs=%b row=%h col=%h", k, fs_n, row_n, col_n, e.fs, ~e.row, ~e.col);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_corner();
    test_offscreen();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
